// File: rtl/stereolbm_pkg.sv
// Shared definitions for the stereo block-matching disparity stages.
package stereolbm_pkg;

   localparam int NDISP_DEF  = 32;
   localparam int COST_W_DEF = 16;
   localparam int DISP_W_DEF = 6;
   localparam int UR_W_DEF   = 7;

   // Uniqueness ratio is expressed in percent.
   localparam int UR_SCALE   = 100;

   typedef enum logic [1:0] {
      ACC,
      EVAL,
      OUT
   } state_t;

endpackage

// File: rtl/stereolbm_uniq_cmp.sv
// Uniqueness-ratio test: rejects a match whose runner-up cost is too close
// to the best cost. Purely combinational so that the left-right check stage
// can reuse it.
module stereolbm_uniq_cmp
   import stereolbm_pkg::*;
#(
   parameter int COST_W = COST_W_DEF,
   parameter int UR_W   = UR_W_DEF
) (
   input  logic [COST_W-1:0] best,
   input  logic [COST_W-1:0] second,
   input  logic [UR_W-1:0]   uniq_ratio,
   output logic              reject
);

   logic [31:0]       ur_wide;
   logic [6:0]        ur;
   logic [6:0]        scale;
   logic [COST_W+6:0] lhs;
   logic [COST_W+6:0] rhs;

   // Widen first so the clamp to 99 is correct for any UR_W.
   assign ur_wide = 32'(uniq_ratio);
   assign ur      = (ur_wide > 32'd99) ? 7'd99 : 7'(ur_wide);
   assign scale   = 7'(UR_SCALE) - ur;

   // Full-precision products: COST_W bits times a value <= 100 fits in COST_W+7.
   assign lhs    = (COST_W+7)'(second) * (COST_W+7)'(scale);
   assign rhs    = (COST_W+7)'(best)   * (COST_W+7)'(UR_SCALE);
   assign reject = (lhs < rhs);

endmodule

// File: rtl/stereolbm_disp_wta.sv
// Winner-take-all disparity selector: tracks the lowest and second-lowest
// cost over NDISP beats per pixel, then emits the winning disparity with a
// uniqueness-reject flag.
module stereolbm_disp_wta
   import stereolbm_pkg::*;
#(
   parameter int NDISP  = NDISP_DEF,
   parameter int COST_W = COST_W_DEF,
   parameter int DISP_W = DISP_W_DEF,
   parameter int UR_W   = UR_W_DEF
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [COST_W-1:0] cost_tdata,
   input  logic              cost_tvalid,
   output logic              cost_tready,
   input  logic              cost_tlast,
   input  logic [UR_W-1:0]   uniq_ratio,
   output logic [DISP_W-1:0] disp_tdata,
   output logic              disp_tuser,
   output logic              disp_tvalid,
   input  logic              disp_tready,
   output logic              proto_err
);

   state_t            state;
   logic [DISP_W-1:0] d_cnt;
   logic [COST_W-1:0] best;
   logic [COST_W-1:0] second;
   logic [DISP_W-1:0] best_d;
   logic              d_last;
   logic              cost_hs;
   logic              reject;

   assign d_last  = (d_cnt == DISP_W'(NDISP - 1));
   assign cost_hs = cost_tvalid && cost_tready;

   stereolbm_uniq_cmp #(
      .COST_W (COST_W),
      .UR_W   (UR_W)
   ) u_uniq_cmp (
      .best       (best),
      .second     (second),
      .uniq_ratio (uniq_ratio),
      .reject     (reject)
   );

   // Accumulate best/second per pixel, evaluate once, then hold the result
   // until the downstream stage takes it.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values; later assignments in the same branch override
   // earlier defaults (e.g. cost_tready).
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= ACC;
         d_cnt       <= '0;
         best        <= '0;
         best_d      <= '0;
         second      <= '1;
         cost_tready <= 1'b0;
         disp_tdata  <= '0;
         disp_tuser  <= 1'b0;
         disp_tvalid <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               cost_tready <= 1'b1;
               if (cost_hs) begin
                  // tlast is advisory; a disagreement is only recorded.
                  if (cost_tlast != d_last)
                     proto_err <= 1'b1;
                  if (d_cnt == '0) begin
                     best   <= cost_tdata;
                     best_d <= '0;
                     second <= '1;
                  end else if (cost_tdata < best) begin
                     second <= best;
                     best   <= cost_tdata;
                     best_d <= d_cnt;
                  end else if (cost_tdata < second) begin
                     second <= cost_tdata;
                  end
                  if (d_last) begin
                     d_cnt       <= '0;
                     state       <= EVAL;
                     cost_tready <= 1'b0;
                  end else begin
                     d_cnt <= d_cnt + 1'b1;
                  end
               end
            end
            EVAL: begin
               disp_tdata  <= best_d;
               disp_tuser  <= reject;
               disp_tvalid <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (disp_tready) begin
                  disp_tvalid <= 1'b0;
                  cost_tready <= 1'b1;
                  state       <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule
